accel_tilt_reader: RTL
======================

Name: accel_tilt_reader

Overview:
- SPI master that configures an ADXL362 accelerometer and samples its X/Y axes periodically.
- Converts each 12-bit reading into a saturated 5-bit two's-complement tilt.
- Packs both tilts into the 10-bit movementData bus consumed by the VGA maze/player stage.
- Sits directly upstream of that stage; the board-level top wires movementData straight through.

Parameters:
- CLK_HZ, 100_000_000, in_clk frequency.
- SCLK_HZ, 1_000_000, SPI clock rate. HALF = CLK_HZ/(2*SCLK_HZ) = 50 cycles.
- BOOT_CYCLES, 1_000_000, wait after reset before the first SPI access (10 ms).
- SAMPLE_CYCLES, 1_666_666, period between read transactions (about 60 Hz).
- SHIFT, 5, arithmetic right shift applied to the 12-bit raw value before saturation.
- CS_IDLE_CYCLES, 100, minimum cs_n high time between transactions.

Ports:
- in_clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- miso  in  1  SPI data from the sensor.
- sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- mosi  out  1  SPI data to the sensor, MSB first.
- cs_n  out  1  SPI chip select, active-low.
- movementData  out  10  {x_tilt[4:0], y_tilt[4:0]}, each two's complement in -16..15.
- sample_valid  out  1  one-cycle pulse when movementData updates.
- cfg_done  out  1  high once the POWER_CTL write has completed; stays high until reset.

Behaviour:
- Reset (async assert, sync deassert internally): cs_n=1, sclk=0, mosi=0, movementData=0, sample_valid=0, cfg_done=0, FSM=BOOT, all counters 0.
- FSM states:
  - BOOT: count BOOT_CYCLES, then go to CFG.
  - CFG: cs_n low; shift 3 bytes 0x0A, 0x2D, 0x02 (write POWER_CTL = measure). Then cs_n high, set cfg_done=1, go to GAP.
  - GAP: hold cs_n high for CS_IDLE_CYCLES, then go to WAIT.
  - WAIT: wait until the sample counter reaches SAMPLE_CYCLES-1, then go to READ. The sample counter runs free from cfg_done and wraps at SAMPLE_CYCLES-1.
  - READ: cs_n low; shift 0x0B, 0x0E, then 4 dummy 0x00 bytes. Capture XL, XH, YL, YH. Then cs_n high and go to CONV.
  - CONV: one cycle. Compute tilts, update movementData, pulse sample_valid, go to GAP.
- Byte transfer: mosi changes on the sclk falling edge (or at byte start); miso is sampled on the rising edge. Each sclk phase lasts HALF cycles. Consecutive bytes have no gap inside one cs_n assertion. sclk idles low whenever cs_n is high.
- Conversion:
  - raw = {XH[3:0], XL} as a 12-bit signed value (XH[7:4] ignored).
  - s = raw >>> SHIFT, as a signed value.
  - Saturate: s > 15 gives 15; s < -16 gives -16. The result is 5 bits. Same for Y.
- Missed sample: if a sample tick occurs while not in WAIT, it is not queued. At most one read per tick; a late read proceeds on the next tick.
- Reset mid-transaction: cs_n returns high immediately (async) and the sequence restarts at BOOT with CFG repeated.
- movementData holds its last value between samples. sample_valid is never high for two consecutive cycles.

Optional Feature:
- Macro ACCEL_AVG_EN.
- Defined:
  - Each axis keeps a 4-entry history of saturated 5-bit tilts, reset to 0.
  - Output = (sum of 4) >>> 2 (7-bit signed sum, arithmetic shift).
  - sample_valid still pulses once per read, so the first three outputs after reset are attenuated.
- Undefined: output is the instantaneous saturated tilt; CONV latency is unchanged (1 cycle).

Decomposition:
- Package accel_pkg holds:
  - ADXL362 command bytes CMD_WR=0x0A, CMD_RD=0x0B.
  - Register addresses REG_POWER_CTL=0x2D, REG_XDATA_L=0x0E, value PWR_MEASURE=0x02.
  - FSM state enum.
  - Saturation function sat5(signed [11:0]).
- Sub-module spi_byte_shifter (a single-byte mode-0 engine):
  - Inputs: start, tx_byte, HALF.
  - Outputs: rx_byte, done pulse, sclk, mosi.
  - The top FSM controls cs_n and byte sequencing.

Test Plan:
- Reset released with an SPI slave model. After BOOT_CYCLES, cs_n falls, and mosi carries 0x0A, 0x2D, 0x02 over 24 sclk rising edges of 100 cycles each. cfg_done then rises and cs_n stays high for at least CS_IDLE_CYCLES.
- Slave returns X=0x0100, Y=0xFFC0 (-64). After READ, movementData=10'b01000_11110 and sample_valid pulses once.
- Saturation: X=0x07FF, Y=0x0800 (-2048) gives movementData=10'b01111_10000. X=0x001F gives x_tilt=0; X=0xFFFF (-1) gives x_tilt=-1 (11111).
- Reset asserted during byte 4 of READ: cs_n goes high the same cycle, sclk=0, movementData=0. After release the bench sees BOOT then CFG repeated before any READ.
- Period check: consecutive sample_valid pulses are exactly SAMPLE_CYCLES apart. With SAMPLE_CYCLES shortened below the READ length, one read occurs per two ticks and there are no back-to-back pulses.
- With ACCEL_AVG_EN defined, a constant X=0x0100 gives x_tilt=2, 4, 6, 8, then 8 steady.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared constants, FSM state type and tilt saturation helper for the ADXL362 tilt reader.
package accel_pkg;

  localparam logic [7:0] CMD_WR        = 8'h0A;
  localparam logic [7:0] CMD_RD        = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  typedef enum logic [2:0] {
    StBoot,
    StCfg,
    StGap,
    StWait,
    StRead,
    StConv
  } state_e;

  // Clamp a signed value to the 5-bit two's-complement range -16..15.
  function automatic logic [4:0] sat5(input logic signed [11:0] v);
    if (v > 12'sd15) begin
      return 5'b01111;
    end else if (v < -12'sd16) begin
      return 5'b10000;
    end else begin
      return v[4:0];
    end
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Single-byte SPI mode-0 engine: MSB first, mosi set at byte start / sclk fall, miso sampled on rise.
module spi_byte_shifter #(
  parameter int unsigned Half = 50
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic [7:0] rx_byte_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Half - 1);

  logic            busy_q, busy_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic            phase_end;

  assign phase_end = busy_q && (cnt_q == CntMax);
  // Raised in the last cycle of the final high phase so the caller can chain the next
  // byte on the same edge that drops sclk, keeping the low phase exactly Half cycles.
  assign done_o    = phase_end && sclk_q && (bit_q == 3'd7);

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (start_i) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      cnt_d  = '0;
      bit_d  = 3'd0;
      tx_d   = tx_byte_i[6:0];
      mosi_d = tx_byte_i[7];
    end else if (busy_q) begin
      if (phase_end) begin
        cnt_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], miso_i};
        end else begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            busy_d = 1'b0;
          end else begin
            bit_d  = bit_q + 3'd1;
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= 3'd0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign rx_byte_o = rx_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: rtl/accel_tilt_reader.sv
// ADXL362 SPI master: configures measure mode, samples X/Y periodically, emits saturated tilts.
// Define ACCEL_AVG_EN to output a 4-sample moving average of each tilt.
module accel_tilt_reader
  import accel_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SCLK_HZ        = 1_000_000,
  parameter int unsigned BOOT_CYCLES    = 1_000_000,
  parameter int unsigned SAMPLE_CYCLES  = 1_666_666,
  parameter int unsigned SHIFT          = 5,
  parameter int unsigned CS_IDLE_CYCLES = 100
) (
  input  logic       in_clk,
  input  logic       reset,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic [9:0] movementData,
  output logic       sample_valid,
  output logic       cfg_done
);

  localparam int unsigned HALF = CLK_HZ / (2 * SCLK_HZ);

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] samp_q, samp_d;
  logic [2:0]  byte_q, byte_d;
  logic        cs_n_q, cs_n_d;
  logic        cfg_done_q, cfg_done_d;
  logic [7:0]  xl_q, xl_d, yl_q, yl_d;
  logic [3:0]  xh_q, xh_d, yh_q, yh_d;
  logic [9:0]  mdata_q;
  logic        valid_q;
  logic        spi_start, spi_done;
  logic [7:0]  spi_tx, spi_rx;
  logic        tick, conv;
  logic [4:0]  x_tilt, y_tilt, x_out, y_out;

  // Asynchronous assert, synchronous release.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  spi_byte_shifter #(
    .Half(HALF)
  ) u_spi (
    .clk_i    (in_clk),
    .rst_ni   (rst_n),
    .start_i  (spi_start),
    .tx_byte_i(spi_tx),
    .miso_i   (miso),
    .rx_byte_o(spi_rx),
    .done_o   (spi_done),
    .sclk_o   (sclk),
    .mosi_o   (mosi)
  );

  assign tick = cfg_done_q && (samp_q == SAMPLE_CYCLES - 1);
  assign conv = (state_q == StConv);

  always_comb begin
    samp_d = samp_q;
    if (cfg_done_q) begin
      samp_d = (samp_q == SAMPLE_CYCLES - 1) ? 32'd0 : samp_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    cs_n_d     = cs_n_q;
    cfg_done_d = cfg_done_q;
    xl_d       = xl_q;
    xh_d       = xh_q;
    yl_d       = yl_q;
    yh_d       = yh_q;
    spi_start  = 1'b0;
    spi_tx     = 8'h00;
    unique case (state_q)
      StBoot: begin
        if (cnt_q == BOOT_CYCLES - 1) begin
          state_d   = StCfg;
          cnt_d     = 32'd0;
          byte_d    = 3'd0;
          cs_n_d    = 1'b0;
          spi_start = 1'b1;
          spi_tx    = CMD_WR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StCfg: begin
        if (spi_done) begin
          if (byte_q == 3'd2) begin
            state_d    = StGap;
            cnt_d      = 32'd0;
            cs_n_d     = 1'b1;
            cfg_done_d = 1'b1;
          end else begin
            byte_d    = byte_q + 3'd1;
            spi_start = 1'b1;
            spi_tx    = (byte_q == 3'd0) ? REG_POWER_CTL : PWR_MEASURE;
          end
        end
      end
      StGap: begin
        if (cnt_q == CS_IDLE_CYCLES - 1) begin
          state_d = StWait;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWait: begin
        // Ticks that land outside WAIT are dropped, never queued.
        if (tick) begin
          state_d   = StRead;
          byte_d    = 3'd0;
          cs_n_d    = 1'b0;
          spi_start = 1'b1;
          spi_tx    = CMD_RD;
        end
      end
      StRead: begin
        if (spi_done) begin
          case (byte_q)
            3'd2:    xl_d = spi_rx;
            3'd3:    xh_d = spi_rx[3:0];
            3'd4:    yl_d = spi_rx;
            3'd5:    yh_d = spi_rx[3:0];
            default: ;
          endcase
          if (byte_q == 3'd5) begin
            state_d = StConv;
            cs_n_d  = 1'b1;
          end else begin
            byte_d    = byte_q + 3'd1;
            spi_start = 1'b1;
            spi_tx    = (byte_q == 3'd0) ? REG_XDATA_L : 8'h00;
          end
        end
      end
      StConv: begin
        state_d = StGap;
        cnt_d   = 32'd0;
      end
      default: state_d = StBoot;
    endcase
  end

  assign x_tilt = sat5($signed({xh_q, xl_q}) >>> SHIFT);
  assign y_tilt = sat5($signed({yh_q, yl_q}) >>> SHIFT);

`ifdef ACCEL_AVG_EN
  logic [2:0][4:0] hx_q, hy_q;

  // Sum of the new tilt and three previous ones; bits [6:2] are the sum >>> 2.
  function automatic logic [4:0] avg4(input logic [4:0] n, input logic [2:0][4:0] h);
    logic [6:0] s;
    s = {{2{n[4]}}, n} + {{2{h[0][4]}}, h[0]} + {{2{h[1][4]}}, h[1]} + {{2{h[2][4]}}, h[2]};
    return s[6:2];
  endfunction

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      hx_q <= '0;
      hy_q <= '0;
    end else if (conv) begin
      hx_q <= {hx_q[1:0], x_tilt};
      hy_q <= {hy_q[1:0], y_tilt};
    end
  end

  assign x_out = avg4(x_tilt, hx_q);
  assign y_out = avg4(y_tilt, hy_q);
`else
  assign x_out = x_tilt;
  assign y_out = y_tilt;
`endif

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      cnt_q      <= 32'd0;
      samp_q     <= 32'd0;
      byte_q     <= 3'd0;
      cs_n_q     <= 1'b1;
      cfg_done_q <= 1'b0;
      xl_q       <= 8'h00;
      xh_q       <= 4'h0;
      yl_q       <= 8'h00;
      yh_q       <= 4'h0;
      mdata_q    <= 10'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      byte_q     <= byte_d;
      cs_n_q     <= cs_n_d;
      cfg_done_q <= cfg_done_d;
      xl_q       <= xl_d;
      xh_q       <= xh_d;
      yl_q       <= yl_d;
      yh_q       <= yh_d;
      valid_q    <= conv;
      if (conv) begin
        mdata_q <= {x_out, y_out};
      end
    end
  end

  assign cs_n         = cs_n_q;
  assign cfg_done     = cfg_done_q;
  assign movementData = mdata_q;
  assign sample_valid = valid_q;

endmodule
